// File: rtl/fetch_queue.sv
// Fetch stage with an in-order prefetch buffer, credit-limited instruction memory requests and branch flush.
// Optional statistics counters (redirect_count, stall_count) are enabled by defining FETCH_STATS_EN.
module fetch_queue #(
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_pc,
    input  logic        branch,
    input  logic [63:0] pc_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] instruction,
    output logic [63:0] pc_current_instruction,
    output logic [63:0] pc_next_instruction
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] redirect_count,
    output logic [31:0] stall_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAXO_W  = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [63:0]   req_pc_q, req_pc_d;
    logic [63:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0] ins_mem [DEPTH];
    logic [63:0] pc_mem  [DEPTH];

    logic [CW-1:0] count;
    logic [CW:0]   credit_sum;
    logic          empty;
    logic          accept;
    logic          pop;
    logic          push;
    logic [PW-1:0] rd_idx;
    logic [PW-1:0] wr_idx;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign empty      = (count == '0);
    assign credit_sum = {1'b0, count} + {1'b0, outst_q};
    assign rd_idx     = rd_ptr_q[PW-1:0];
    assign wr_idx     = wr_ptr_q[PW-1:0];

    // Every accepted request reserves a buffer slot, so a returning response can always be written.
    assign imem_req_valid = !reset_pc && !branch && (credit_sum < DEPTH_W) && (outst_q < MAXO_W);
    assign imem_req_addr  = req_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign fetch_valid = !empty && !branch;
    assign pop         = fetch_valid && fetch_ready;
    assign push        = imem_rsp_valid && (drop_q == '0) && !branch;

    always_comb begin
        instruction            = NOP;
        pc_current_instruction = 64'h0;
        pc_next_instruction    = 64'h0;
        if (!empty) begin
            instruction            = ins_mem[rd_idx];
            pc_current_instruction = pc_mem[rd_idx];
            pc_next_instruction    = pc_mem[rd_idx] + 64'd4;
        end
    end

    always_comb begin
        req_pc_d = req_pc_q;
        rsp_pc_d = rsp_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        if (branch) begin
            // Everything still in flight belongs to the wrong path; a response landing now is discarded too.
            req_pc_d = {pc_target[63:2], 2'b00};
            rsp_pc_d = {pc_target[63:2], 2'b00};
            rd_ptr_d = wr_ptr_q;
            outst_d  = outst_q - CW'(imem_rsp_valid);
            drop_d   = outst_q - CW'(imem_rsp_valid);
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + 64'd4;
            end
            outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid);
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    rsp_pc_d = rsp_pc_q + 64'd4;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset_pc) begin
        if (reset_pc) begin
            req_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            req_pc_q <= req_pc_d;
            rsp_pc_q <= rsp_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage needs no reset: entries are only visible between write and read pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            ins_mem[wr_idx] <= imem_rsp_data;
            pc_mem[wr_idx]  <= rsp_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] redirect_count_q, redirect_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        redirect_count_d = redirect_count_q + 32'(branch);
        stall_count_d    = stall_count_q + 32'(fetch_valid && !fetch_ready);
    end

    always_ff @(posedge clock or posedge reset_pc) begin
        if (reset_pc) begin
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
    assign stall_count    = stall_count_q;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model plus a program-order PC scoreboard.
module tb_fetch_queue;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          MAXO     = 2;

    logic        clock = 1'b0;
    logic        reset_pc;
    logic        branch;
    logic [63:0] pc_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] instruction;
    logic [63:0] pc_current_instruction;
    logic [63:0] pc_next_instruction;
`ifdef FETCH_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset_pc(reset_pc), .branch(branch), .pc_target(pc_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .instruction(instruction),
        .pc_current_instruction(pc_current_instruction), .pc_next_instruction(pc_next_instruction)
`ifdef FETCH_STATS_EN
        , .redirect_count(redirect_count), .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // stimulus knobs
    logic        br = 1'b0, rdy = 1'b1, frdy = 1'b1;
    logic [63:0] tgt = 64'h0;
    int          rsp_pct = 100;

    // reference state: memory queue, program-order expectations
    logic [63:0] memq [$];
    logic [63:0] exp_pc, exp_req;
    int          exp_redir, exp_stall;

    // per-cycle samples
    logic        s_req_valid, s_rdy, s_acc, s_rsp, s_fetch_valid, s_pop, s_branch;
    logic [63:0] s_addr, s_acc_exp, s_pop_pc, s_pop_next, s_pop_exp;
    logic [31:0] s_pop_ins;
    logic        prev_hold;
    logic [63:0] prev_addr;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        reset_pc = 1'b1; branch = 1'b0; pc_target = 64'h0;
        imem_req_ready = 1'b0; fetch_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        memq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_pc = 1'b0;
        exp_pc = RESET_PC; exp_req = RESET_PC;
        exp_redir = 0; exp_stall = 0;
        prev_hold = 1'b0; prev_addr = 64'h0;
        s_req_valid = 1'b0; s_rdy = 1'b0; s_branch = 1'b0; s_addr = 64'h0;
    endtask

    // One clock: apply knobs, sample at negedge, then advance the memory model and scoreboard.
    task automatic cycle();
        prev_hold = s_req_valid && !s_rdy && !s_branch;
        prev_addr = s_addr;
        branch = br; pc_target = tgt; imem_req_ready = rdy; fetch_ready = frdy;
        @(negedge clock);
        s_req_valid   = imem_req_valid;
        s_rdy         = imem_req_ready;
        s_addr        = imem_req_addr;
        s_acc         = imem_req_valid && imem_req_ready;
        s_acc_exp     = exp_req;
        s_rsp         = imem_rsp_valid;
        s_fetch_valid = fetch_valid;
        s_pop         = fetch_valid && fetch_ready;
        s_pop_pc      = pc_current_instruction;
        s_pop_next    = pc_next_instruction;
        s_pop_ins     = instruction;
        s_pop_exp     = exp_pc;
        s_branch      = branch;
        @(posedge clock);
        #1;
        if (s_acc) memq.push_back(s_addr);
        if (s_rsp && memq.size() > 0) void'(memq.pop_front());
        if (s_branch) begin
            exp_pc  = {tgt[63:2], 2'b00};
            exp_req = {tgt[63:2], 2'b00};
            exp_redir++;
        end else begin
            if (s_pop) exp_pc  = exp_pc + 64'd4;
            if (s_acc) exp_req = exp_req + 64'd4;
        end
        if (s_fetch_valid && !fetch_ready) exp_stall++;
        if (memq.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = memfn(memq[0]);
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        end
        cyc++;
    endtask

    task automatic test_reset();
        reset_pc = 1'b1; branch = 1'b0; pc_target = 64'h0; imem_req_ready = 1'b1; fetch_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        @(posedge clock); #1;
        nvec++;
        if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_valids: req_valid=%b fetch_valid=%b, required 0 0", imem_req_valid, fetch_valid);
        end
        nvec++;
        if (instruction !== 32'h13 || pc_current_instruction !== 64'h0 || pc_next_instruction !== 64'h0) begin
            nerr++; $display("FAIL reset_head: ins=%h pc=%h next=%h, required 00000013 0 0",
                             instruction, pc_current_instruction, pc_next_instruction);
        end
        $display("reset: req_valid=%b fetch_valid=%b ins=%h", imem_req_valid, fetch_valid, instruction);
    endtask

    task automatic test_stream();
        int acc_cyc, pop_cyc, npop;
        do_reset();
        br = 0; rdy = 1; frdy = 1; rsp_pct = 100;
        acc_cyc = -1; pop_cyc = -1; npop = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (s_acc && acc_cyc < 0) acc_cyc = cyc;
            if (s_pop && pop_cyc < 0) pop_cyc = cyc;
            if (s_acc) begin
                nvec++;
                if (s_acc_addr_bad()) begin
                    nerr++; $display("FAIL stream_req: addr=%h required %h", s_addr, s_acc_exp);
                end
            end
            if (s_pop) begin
                npop++; nvec++;
                if (s_pop_pc !== s_pop_exp || s_pop_ins !== memfn(s_pop_exp) || s_pop_next !== s_pop_exp + 64'd4) begin
                    nerr++; $display("FAIL stream_pop: pc=%h ins=%h next=%h required pc=%h ins=%h next=%h",
                                     s_pop_pc, s_pop_ins, s_pop_next, s_pop_exp, memfn(s_pop_exp), s_pop_exp + 64'd4);
                end
                $display("stream: cyc=%0d pop pc=%h ins=%h", cyc, s_pop_pc, s_pop_ins);
            end
        end
        nvec++;
        if (acc_cyc < 0 || pop_cyc - acc_cyc != 2) begin
            nerr++; $display("FAIL stream_latency: first pop %0d cycles after first accept, required 2", pop_cyc - acc_cyc);
        end
        nvec++;
        if (pop_cyc < 0 || npop != 16 - (pop_cyc - (cyc - 16) - 1)) begin
            nerr++; $display("FAIL stream_throughput: pops=%0d after first pop, required one per cycle", npop);
        end
    endtask

    function automatic logic s_acc_addr_bad();
        return s_addr !== s_acc_exp;
    endfunction

    task automatic test_stall();
        logic [63:0] head;
        frdy = 0; rdy = 1; rsp_pct = 100;
        head = exp_pc;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_fetch_valid) begin
                nvec++;
                if (s_pop_pc !== head) begin
                    nerr++; $display("FAIL stall_head: pc=%h required %h", s_pop_pc, head);
                end
            end
        end
        nvec++;
        if (s_req_valid !== 1'b0 || s_fetch_valid !== 1'b1 || memq.size() != 0) begin
            nerr++; $display("FAIL stall_full: req_valid=%b fetch_valid=%b in_flight=%0d, required 0 1 0",
                             s_req_valid, s_fetch_valid, memq.size());
        end
        $display("stall: head pc=%h req_valid=%b", s_pop_pc, s_req_valid);
        frdy = 1; rsp_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            nvec++;
            if (s_pop !== 1'b1 || s_pop_pc !== s_pop_exp || s_pop_ins !== memfn(s_pop_exp)) begin
                nerr++; $display("FAIL stall_drain: pop=%b pc=%h required pop=1 pc=%h", s_pop, s_pop_pc, s_pop_exp);
            end
        end
        rsp_pct = 100;
    endtask

    task automatic test_branch();
        int got;
        logic [63:0] want;
        rsp_pct = 0; frdy = 1; rdy = 1;
        for (int i = 0; i < 10 && memq.size() < 2; i++) cycle();
        nvec++;
        if (memq.size() != 2) begin
            nerr++; $display("FAIL branch_setup: outstanding=%0d required 2", memq.size());
        end
        br = 1; tgt = 64'h203; rsp_pct = 100;
        cycle();
        br = 0;
        nvec++;
        if (s_req_valid !== 1'b0 || s_fetch_valid !== 1'b0) begin
            nerr++; $display("FAIL branch_cycle: req_valid=%b fetch_valid=%b required 0 0", s_req_valid, s_fetch_valid);
        end
        got = 0;
        for (int i = 0; i < 20 && got < 2; i++) begin
            cycle();
            if (s_pop) begin
                want = (got == 0) ? 64'h200 : 64'h204;
                nvec++;
                if (s_pop_pc !== want || s_pop_ins !== memfn(want)) begin
                    nerr++; $display("FAIL branch_pop%0d: pc=%h ins=%h required pc=%h ins=%h", got, s_pop_pc, s_pop_ins, want, memfn(want));
                end
                $display("branch: pop pc=%h", s_pop_pc);
                got++;
            end
        end
        nvec++;
        if (got != 2) begin
            nerr++; $display("FAIL branch_timeout: pops=%0d required 2", got);
        end
    endtask

    task automatic test_req_stall();
        rdy = 0; frdy = 1; rsp_pct = 100;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (prev_hold && !s_branch) begin
                nvec++;
                if (s_req_valid !== 1'b1 || s_addr !== prev_addr) begin
                    nerr++; $display("FAIL req_hold: valid=%b addr=%h required 1 %h", s_req_valid, s_addr, prev_addr);
                end
            end
        end
        rdy = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_acc) begin
                nvec++;
                if (s_addr !== s_acc_exp) begin
                    nerr++; $display("FAIL req_seq: addr=%h required %h", s_addr, s_acc_exp);
                end
                $display("req_stall: accept addr=%h", s_addr);
            end
            if (s_pop) begin
                nvec++;
                if (s_pop_pc !== s_pop_exp || s_pop_ins !== memfn(s_pop_exp)) begin
                    nerr++; $display("FAIL req_pop: pc=%h required %h", s_pop_pc, s_pop_exp);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] want;
        int got;
        br = 1; tgt = 64'hFFFF_FFFF_FFFF_FFF8; rdy = 1; frdy = 1; rsp_pct = 100;
        cycle();
        br = 0; got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            cycle();
            if (s_pop) begin
                want = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * got);
                nvec++;
                if (s_pop_pc !== want || s_pop_next !== want + 64'd4 || s_pop_ins !== memfn(want)) begin
                    nerr++; $display("FAIL wrap%0d: pc=%h next=%h required pc=%h next=%h", got, s_pop_pc, s_pop_next, want, want + 64'd4);
                end
                $display("wrap: pop pc=%h next=%h", s_pop_pc, s_pop_next);
                got++;
            end
        end
        nvec++;
        if (got != 3) begin
            nerr++; $display("FAIL wrap_timeout: pops=%0d required 3", got);
        end
    endtask

    task automatic test_async_reset();
        int got;
        rsp_pct = 0; rdy = 1; frdy = 1;
        for (int i = 0; i < 10 && memq.size() < 2; i++) cycle();
        #2;
        reset_pc = 1'b1;
        #1;
        nvec++;
        if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || instruction !== 32'h13) begin
            nerr++; $display("FAIL async_reset: req_valid=%b fetch_valid=%b ins=%h required 0 0 00000013",
                             imem_req_valid, fetch_valid, instruction);
        end
        $display("async_reset: in_flight=%0d req_valid=%b", memq.size(), imem_req_valid);
        memq.delete(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        @(posedge clock); #1;
        reset_pc = 1'b0;
        exp_pc = RESET_PC; exp_req = RESET_PC; exp_redir = 0; exp_stall = 0;
        s_req_valid = 1'b0; s_branch = 1'b0;
        rsp_pct = 100; got = 0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            cycle();
            if (s_acc && got == 0) begin
                nvec++;
                if (s_addr !== RESET_PC) begin
                    nerr++; $display("FAIL refetch_addr: addr=%h required %h", s_addr, RESET_PC);
                end
                got = 1;
            end
            if (s_pop) begin
                nvec++;
                if (s_pop_pc !== RESET_PC || s_pop_ins !== memfn(RESET_PC)) begin
                    nerr++; $display("FAIL refetch_pop: pc=%h required %h", s_pop_pc, RESET_PC);
                end
                got = 2;
            end
        end
        nvec++;
        if (got != 2) begin
            nerr++; $display("FAIL refetch_timeout: stage=%0d required 2", got);
        end
    endtask

    task automatic test_random();
        rsp_pct = 60;
        for (int i = 0; i < 600; i++) begin
            br   = ($urandom_range(0, 99) < 5);
            tgt  = {$urandom, $urandom};
            rdy  = ($urandom_range(0, 99) < 70);
            frdy = ($urandom_range(0, 99) < 70);
            cycle();
            if (s_acc) begin
                nvec++;
                if (s_addr !== s_acc_exp) begin
                    nerr++; $display("FAIL rand_req: cyc=%0d addr=%h required %h", cyc, s_addr, s_acc_exp);
                end
            end
            if (s_pop) begin
                nvec++;
                if (s_pop_pc !== s_pop_exp || s_pop_ins !== memfn(s_pop_exp) || s_pop_next !== s_pop_exp + 64'd4) begin
                    nerr++; $display("FAIL rand_pop: cyc=%0d pc=%h ins=%h required pc=%h ins=%h",
                                     cyc, s_pop_pc, s_pop_ins, s_pop_exp, memfn(s_pop_exp));
                end
                $display("random: cyc=%0d pop pc=%h", cyc, s_pop_pc);
            end
            if (s_branch) begin
                nvec++;
                if (s_req_valid !== 1'b0 || s_fetch_valid !== 1'b0) begin
                    nerr++; $display("FAIL rand_branch: cyc=%0d req_valid=%b fetch_valid=%b required 0 0", cyc, s_req_valid, s_fetch_valid);
                end
            end else if (prev_hold) begin
                nvec++;
                if (s_req_valid !== 1'b1 || s_addr !== prev_addr) begin
                    nerr++; $display("FAIL rand_hold: cyc=%0d valid=%b addr=%h required 1 %h", cyc, s_req_valid, s_addr, prev_addr);
                end
            end
            nvec++;
            if (memq.size() > MAXO) begin
                nerr++; $display("FAIL rand_outstanding: cyc=%0d outstanding=%0d required <= %0d", cyc, memq.size(), MAXO);
            end
        end
`ifdef FETCH_STATS_EN
        nvec++;
        if (redirect_count !== 32'(exp_redir) || stall_count !== 32'(exp_stall)) begin
            nerr++; $display("FAIL stats: redirect=%0d stall=%0d required %0d %0d", redirect_count, stall_count, exp_redir, exp_stall);
        end
`endif
        br = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_req_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
